// File: rtl/serial_frame_receiver_if.sv
// Bundle between the serial link, the receiver and the RB2 register bank.
// Groups the one-wire-plus-enable stream and the RB2 write port.
interface serial_frame_receiver_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 18
);
    // sen is active low and frames a burst of sd bits (MSB first, sampled on
    // rising clk); RB2_RW is an active-low write strobe, low for exactly one
    // cycle per accepted frame, with RB2_A/RB2_D stable while it is low.
    logic              sen;
    logic              sd;
    logic              RB2_RW;
    logic [ADDR_W-1:0] RB2_A;
    logic [DATA_W-1:0] RB2_D;
    logic [DATA_W-1:0] RB2_Q;
    logic              S2_done;
    logic [2:0]        fsm_state;

    modport slave (
        input  sen, sd, RB2_Q,
        output RB2_RW, RB2_A, RB2_D, S2_done, fsm_state
    );

    modport master (
        output sen, sd, RB2_Q,
        input  RB2_RW, RB2_A, RB2_D, S2_done, fsm_state
    );
endinterface

// File: rtl/serial_frame_receiver.sv
// Captures address+data frames from the sen/sd stream and writes them into
// RB2; raises S2_done once every RB2 location has been written at least once.
module serial_frame_receiver #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 18
) (
    input logic                    clk,
    input logic                    rst,
    serial_frame_receiver_if.slave bus
);
    localparam int FRAME_W = ADDR_W + DATA_W;
    localparam int DEPTH   = 1 << ADDR_W;
    localparam int CNT_W   = $clog2(FRAME_W);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        WRITE = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [FRAME_W-1:0]  shift_q, shift_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DEPTH-1:0]    written_q, written_d;
    logic                rw_q, rw_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                done_q, done_d;

    logic [FRAME_W-1:0]  frame_w;
    logic [DEPTH-1:0]    written_set;
    logic                unused_rb2_q;

    assign frame_w      = {shift_q[FRAME_W-2:0], bus.sd};
    assign written_set  = written_q | (DEPTH'(1) << addr_q);
    assign unused_rb2_q = ^bus.RB2_Q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            written_q <= '0;
            rw_q      <= 1'b1;
            addr_q    <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            written_q <= written_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        written_d = written_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        data_d    = data_q;
        done_d    = done_q;
        case (state_q)
            IDLE: begin
                if (!bus.sen) begin
                    shift_d = frame_w;
                    cnt_d   = CNT_W'(1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.sen) begin
                    // Partial frame: drop it without touching RB2.
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(FRAME_W - 1)) begin
                    addr_d  = frame_w[FRAME_W-1:DATA_W];
                    data_d  = frame_w[DATA_W-1:0];
                    rw_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = WRITE;
                end else begin
                    shift_d = frame_w;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            WRITE: begin
                rw_d      = 1'b1;
                written_d = written_set;
                if (&written_set) begin
                    state_d = DONE;
                end else if (!bus.sen) begin
                    state_d = FLUSH;
                end else begin
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                if (bus.sen) begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                // Raised one edge after entering DONE so the last write has landed.
                done_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.RB2_RW    = rw_q;
    assign bus.RB2_A     = addr_q;
    assign bus.RB2_D     = data_q;
    assign bus.S2_done   = done_q;
    assign bus.fsm_state = state_q;
endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed bench for serial_frame_receiver with a behavioural RB2 model.
module tb_serial_frame_receiver;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_frame_receiver_if #(.ADDR_W(3), .DATA_W(18)) bus ();
    serial_frame_receiver #(.ADDR_W(3), .DATA_W(18)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [17:0] rb2_mem [8];
    int pulse_cnt;

    // RB2 model: synchronous write while WENn is low.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) rb2_mem[i] <= '0;
            pulse_cnt <= 0;
        end else if (bus.RB2_RW === 1'b0) begin
            rb2_mem[bus.RB2_A] <= bus.RB2_D;
            pulse_cnt <= pulse_cnt + 1;
        end
    end

    task automatic apply_reset();
        rst = 1'b1; bus.sen = 1'b1; bus.sd = 1'b0; bus.RB2_Q = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Drives n bits with sen low, MSB of f first; bits beyond 21 are random.
    task automatic drive_bits(input logic [20:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.sen = 1'b0;
            bus.sd  = (i < 21) ? f[20-i] : 1'($urandom_range(0, 1));
        end
    endtask

    task automatic send_frame(input logic [2:0] a, input logic [17:0] d, input bit expect_write);
        drive_bits({a, d}, 21);
        @(negedge clk);
        bus.sen = 1'b1; bus.sd = 1'b0;
        n_checks++;
        if (bus.RB2_RW !== !expect_write) begin
            n_fail++; $display("FAIL frame_rw_k: got %b expected %b (addr %0d)", bus.RB2_RW, !expect_write, a);
        end
        if (expect_write) begin
            n_checks++;
            if (bus.RB2_A !== a) begin
                n_fail++; $display("FAIL frame_addr: got %0d expected %0d", bus.RB2_A, a);
            end
            n_checks++;
            if (bus.RB2_D !== d) begin
                n_fail++; $display("FAIL frame_data: got %h expected %h", bus.RB2_D, d);
            end
        end
        @(negedge clk);
        n_checks++;
        if (bus.RB2_RW !== 1'b1) begin
            n_fail++; $display("FAIL frame_rw_k1: got %b expected 1 (addr %0d)", bus.RB2_RW, a);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.sen = 1'b1; bus.sd = 1'b0; bus.RB2_Q = '0;
        @(negedge clk);
        n_checks++;
        if (bus.RB2_RW !== 1'b1) begin n_fail++; $display("FAIL reset_rw: got %b expected 1", bus.RB2_RW); end
        n_checks++;
        if (bus.RB2_A !== 3'd0) begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", bus.RB2_A); end
        n_checks++;
        if (bus.RB2_D !== 18'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", bus.RB2_D); end
        n_checks++;
        if (bus.S2_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.S2_done); end
        n_checks++;
        if (bus.fsm_state !== S_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", bus.fsm_state, S_IDLE); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        apply_reset();
        send_frame(3'b011, 18'h2A5C3, 1'b1);
        repeat (4) @(negedge clk);
        n_checks++;
        if (rb2_mem[3] !== 18'h2A5C3) begin n_fail++; $display("FAIL single_mem: got %h expected 2a5c3", rb2_mem[3]); end
        n_checks++;
        if (pulse_cnt !== 1) begin n_fail++; $display("FAIL single_pulses: got %0d expected 1", pulse_cnt); end
        n_checks++;
        if (bus.S2_done !== 1'b0) begin n_fail++; $display("FAIL single_done: got %b expected 0", bus.S2_done); end
    endtask

    task automatic test_abort();
        apply_reset();
        drive_bits({3'd6, 18'h15555}, 12);
        @(negedge clk);
        bus.sen = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.fsm_state !== S_IDLE) begin n_fail++; $display("FAIL abort_state: got %0d expected %0d", bus.fsm_state, S_IDLE); end
        n_checks++;
        if (pulse_cnt !== 0) begin n_fail++; $display("FAIL abort_pulses: got %0d expected 0", pulse_cnt); end
        send_frame(3'd5, 18'h3FFFF, 1'b1);
        n_checks++;
        if (rb2_mem[5] !== 18'h3FFFF) begin n_fail++; $display("FAIL abort_mem5: got %h expected 3ffff", rb2_mem[5]); end
        n_checks++;
        if (pulse_cnt !== 1) begin n_fail++; $display("FAIL abort_pulses2: got %0d expected 1", pulse_cnt); end
    endtask

    task automatic test_overlong();
        apply_reset();
        drive_bits({3'd2, 18'h12345}, 30);
        @(negedge clk);
        n_checks++;
        if (bus.fsm_state !== S_FLUSH) begin n_fail++; $display("FAIL overlong_state: got %0d expected %0d", bus.fsm_state, S_FLUSH); end
        bus.sen = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.fsm_state !== S_IDLE) begin n_fail++; $display("FAIL overlong_idle: got %0d expected %0d", bus.fsm_state, S_IDLE); end
        n_checks++;
        if (rb2_mem[2] !== 18'h12345) begin n_fail++; $display("FAIL overlong_mem2: got %h expected 12345", rb2_mem[2]); end
        n_checks++;
        if (pulse_cnt !== 1) begin n_fail++; $display("FAIL overlong_pulses: got %0d expected 1", pulse_cnt); end
    endtask

    task automatic test_nominal();
        apply_reset();
        for (int a = 0; a < 8; a++) send_frame(3'(a), 18'(a + 1), 1'b1);
        n_checks++;
        if (bus.S2_done !== 1'b0) begin n_fail++; $display("FAIL nominal_done_k1: got %b expected 0", bus.S2_done); end
        @(negedge clk);
        n_checks++;
        if (bus.S2_done !== 1'b1) begin n_fail++; $display("FAIL nominal_done_k2: got %b expected 1", bus.S2_done); end
        for (int a = 0; a < 8; a++) begin
            n_checks++;
            if (rb2_mem[a] !== 18'(a + 1)) begin n_fail++; $display("FAIL nominal_mem%0d: got %h expected %h", a, rb2_mem[a], 18'(a + 1)); end
        end
        n_checks++;
        if (pulse_cnt !== 8) begin n_fail++; $display("FAIL nominal_pulses: got %0d expected 8", pulse_cnt); end
    endtask

    task automatic test_duplicates();
        logic [2:0]  addrs [9];
        logic [17:0] datas [9];
        addrs = '{3'd7, 3'd6, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        datas = '{18'h0A007, 18'h0B006, 18'h0C006, 18'h0D005, 18'h0E004,
                  18'h0F003, 18'h10002, 18'h11001, 18'h12000};
        apply_reset();
        for (int i = 0; i < 8; i++) send_frame(addrs[i], datas[i], 1'b1);
        n_checks++;
        if (bus.S2_done !== 1'b0) begin n_fail++; $display("FAIL dup_done_early: got %b expected 0", bus.S2_done); end
        send_frame(addrs[8], datas[8], 1'b1);
        @(negedge clk);
        n_checks++;
        if (bus.S2_done !== 1'b1) begin n_fail++; $display("FAIL dup_done: got %b expected 1", bus.S2_done); end
        n_checks++;
        if (rb2_mem[6] !== 18'h0C006) begin n_fail++; $display("FAIL dup_mem6: got %h expected 0c006", rb2_mem[6]); end
        n_checks++;
        if (rb2_mem[7] !== 18'h0A007) begin n_fail++; $display("FAIL dup_mem7: got %h expected 0a007", rb2_mem[7]); end
        n_checks++;
        if (rb2_mem[0] !== 18'h12000) begin n_fail++; $display("FAIL dup_mem0: got %h expected 12000", rb2_mem[0]); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        send_frame(3'd4, 18'h00003, 1'b1);
        drive_bits({3'd1, 18'h2AAAA}, 10);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (bus.RB2_A !== 3'd0 || bus.RB2_D !== 18'h0) begin
            n_fail++; $display("FAIL midrst_ad: got %0d/%h expected 0/0", bus.RB2_A, bus.RB2_D);
        end
        n_checks++;
        if (bus.RB2_RW !== 1'b1 || bus.S2_done !== 1'b0) begin
            n_fail++; $display("FAIL midrst_rw_done: got %b/%b expected 1/0", bus.RB2_RW, bus.S2_done);
        end
        n_checks++;
        if (bus.fsm_state !== S_IDLE) begin n_fail++; $display("FAIL midrst_state: got %0d expected %0d", bus.fsm_state, S_IDLE); end
        @(negedge clk);
        bus.sen = 1'b1; rst = 1'b0;
        @(negedge clk);
        for (int a = 0; a < 8; a++) send_frame(3'(a), 18'(a + 1), 1'b1);
        @(negedge clk);
        n_checks++;
        if (bus.S2_done !== 1'b1) begin n_fail++; $display("FAIL midrst_done: got %b expected 1", bus.S2_done); end
        for (int a = 0; a < 8; a++) begin
            n_checks++;
            if (rb2_mem[a] !== 18'(a + 1)) begin n_fail++; $display("FAIL midrst_mem%0d: got %h expected %h", a, rb2_mem[a], 18'(a + 1)); end
        end
        send_frame(3'd1, 18'h3ABCD, 1'b0);
        send_frame(3'd6, 18'h01234, 1'b0);
        n_checks++;
        if (pulse_cnt !== 8) begin n_fail++; $display("FAIL postdone_pulses: got %0d expected 8", pulse_cnt); end
        n_checks++;
        if (rb2_mem[1] !== 18'h00002) begin n_fail++; $display("FAIL postdone_mem1: got %h expected 00002", rb2_mem[1]); end
        n_checks++;
        if (bus.S2_done !== 1'b1 || bus.fsm_state !== S_DONE) begin
            n_fail++; $display("FAIL postdone_sticky: got %b/%0d expected 1/%0d", bus.S2_done, bus.fsm_state, S_DONE);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_abort();
        test_overlong();
        test_nominal();
        test_duplicates();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_frame_receiver.md
# serial_frame_receiver

Downstream receiver stage of the RB1 → RB2 serial link. It captures 21-bit frames from the `sen`/`sd` one-wire-plus-enable stream produced by the S1 transmitter, writes each 18-bit payload into the RB2 8x18 register bank at the 3-bit address carried in the frame, and asserts `S2_done` once every RB2 location has been written. It drives RB2 directly through the bank's synchronous, active-low write-enable port.

## Interface
- `ADDR_W`, 3: frame address field width; RB2 depth = 2**ADDR_W.
- `DATA_W`, 18: frame payload width; frame length = ADDR_W+DATA_W (21).

- `clk`  in  1  system clock; all sampling on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `sen`  in  1  frame enable, active low; low for the duration of a frame.
- `sd`  in  1  serial data, MSB first, valid while `sen`=0.
- `RB2_RW`  out  1  RB2 WENn: 0 = write at next rising edge, 1 = no write.
- `RB2_A`  out  ADDR_W  RB2 address.
- `RB2_D`  out  DATA_W  RB2 write data.
- `RB2_Q`  in  DATA_W  RB2 read data; unused, ignored.
- `S2_done`  out  1  all RB2 locations written; sticky until reset.

## Operation
- Frame format: bit 20..18 = address, bit 17..0 = data; first bit sampled is bit 20.
- Bit capture: on each rising edge with `sen`=0 in state SHIFT/IDLE, shift `sd` into a 21-bit register; a 5-bit counter counts bits 0..20.
- FSM states:
  - IDLE: `sen`=1. A rising edge with `sen`=0 captures bit 20, counter=1, go to SHIFT.
  - SHIFT: each `sen`=0 edge captures one bit. On the 21st bit, register `RB2_A`/`RB2_D` from {shift[19:0],`sd`}, drive `RB2_RW`=0, and go to WRITE. If `sen`=1 before 21 bits, the partial frame is discarded with no write, the counter clears, and the FSM goes to IDLE.
  - WRITE: one cycle; `RB2_RW`→1 at its end; set `written[RB2_A]`. Next state is FLUSH if `sen`=0, else IDLE. If `written` becomes all ones, go to DONE.
  - FLUSH: `sen` still low after a complete frame; extra bits are ignored. `sen`=1 → IDLE.
  - DONE: `S2_done`=1. All further `sen`/`sd` activity is ignored and `RB2_RW` is held at 1.
- `written` is an 8-bit mask. A duplicate address rewrites RB2 (last frame wins) and does not advance completion.
- At least one `sen`=1 cycle is required between frames; back-to-back low frames are treated as a single frame plus ignored excess.

## Timing
- Reset (async, immediate) values: `RB2_RW`=1, `RB2_A`=0, `RB2_D`=0, `S2_done`=0, `written`=0, counter=0, state IDLE.
- Latency: the 21st bit is sampled at edge k. `RB2_RW`=0 with valid A/D for the cycle k..k+1, and RB2 captures at edge k+1. `RB2_RW`=1 from edge k+1.
- `RB2_RW` is low for exactly one cycle per accepted frame.
- `S2_done` rises at edge k+2 of the frame that completes the mask, after the RB2 write has landed, and stays high until `rst`.
- All outputs are registered; no combinational path from `sen`/`sd` to any output.
- Reset asserted mid-frame: the partial frame is lost. After release, the receiver waits in IDLE; a stream that is still low is captured starting from the next low edge. The bench must raise `sen` before resending.
- An abort on the 21st edge cannot occur: `sen`=0 on that edge completes the frame.

## Test plan
- **Nominal:** 8 frames, addresses 0..7, data 18'h00001·(addr+1), one `sen`=1 cycle between frames.
  - RB2[n]=n+1.
  - Each frame gives one `RB2_RW`=0 pulse at edge k+1.
  - `S2_done`=1 two edges after the last bit.
- **Single frame:** addr 3'b011, data 18'h2A5C3.
  - `RB2_A`=3, `RB2_D`=2A5C3, `RB2_RW` low for exactly one cycle.
  - RB2[3]=2A5C3; `S2_done` stays 0.
- **Aborted frame:** `sen` low for 12 bits then high, followed by a full frame to addr 5 data 18'h3FFFF.
  - No write for the aborted frame.
  - RB2[5]=3FFFF.
- **Overlong enable:** `sen` held low for 30 bits (first 21 = addr 2, data 18'h12345).
  - Exactly one write: RB2[2]=12345.
  - Bits 22..30 are ignored.
- **Duplicates and out-of-order:** addresses 7,6,6,5,4,3,2,1,0 with distinct data.
  - RB2[6] holds the second value.
  - `S2_done` asserts only after the addr-0 frame.
- **Reset mid-frame:** assert `rst` after 10 bits, release, then send the full 8-frame set.
  - Outputs return to reset values immediately.
  - Final contents are correct and `S2_done`=1.
  - Frames sent after done cause no `RB2_RW` pulse.
